// File: rtl/gpu_pkg.sv
// Shared widths, FSM encoding and the triangle bundle consumed by the pixel core.
package gpu_pkg;

  localparam int unsigned VTX_XY_W   = 6;
  localparam int unsigned VTX_Z_W    = 3;
  localparam int unsigned EDGE_XY_W  = 7;
  localparam int unsigned EDGE_Z_W   = 4;
  localparam int unsigned COLOR_W    = 6;
  localparam int unsigned INV_DET_W  = 20;
  localparam int unsigned DET_OUT_W  = 12;
  localparam int unsigned DET_FULL_W = 14;
  localparam int unsigned DIVISOR_W  = 13;

  localparam logic [INV_DET_W-1:0] INV_NUMERATOR = 20'hFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } setup_state_e;

  typedef struct packed {
    logic [VTX_XY_W-1:0]  v0_x;
    logic [VTX_XY_W-1:0]  v0_y;
    logic [VTX_Z_W-1:0]   v0_z;
    logic [EDGE_XY_W-1:0] e1_x;
    logic [EDGE_XY_W-1:0] e1_y;
    logic [EDGE_Z_W-1:0]  e1_z;
    logic [EDGE_XY_W-1:0] e2_x;
    logic [EDGE_XY_W-1:0] e2_y;
    logic [EDGE_Z_W-1:0]  e2_z;
    logic [DET_OUT_W-1:0] determinant;
    logic [INV_DET_W-1:0] inv_det;
    logic [COLOR_W-1:0]   color;
    logic                 en;
  } triangle_cfg_t;

  // Magnitude of the full determinant; |D| never exceeds 63*63*2 so 13 bits suffice.
  function automatic logic [DIVISOR_W-1:0] abs_det(input logic signed [DET_FULL_W-1:0] d);
    return d[DET_FULL_W-1] ? DIVISOR_W'(-d) : DIVISOR_W'(d);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
module seq_divider #(
  parameter int unsigned N_W = 20,
  parameter int unsigned D_W = 13
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           done_c,
  output logic [N_W-1:0] quotient
);

  localparam int unsigned CNT_W = $clog2(N_W);

  logic [N_W-1:0]   quo_q, quo_d;
  logic [D_W-1:0]   rem_q, rem_d;
  logic [D_W-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [D_W:0]     trial_c;
  logic             fits_c;

  // Trial subtraction: shift the next dividend bit into the partial remainder.
  always_comb begin
    trial_c = {rem_q, quo_q[N_W-1]};
    fits_c  = (trial_c >= {1'b0, dvs_q});
  end

  // Iteration control; quo_q doubles as the dividend shift register.
  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_c = 1'b0;
    if (start) begin
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
      cnt_d = CNT_W'(N_W - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      quo_d = {quo_q[N_W-2:0], fits_c};
      rem_d = fits_c ? D_W'(trial_c - {1'b0, dvs_q}) : D_W'(trial_c);
      if (cnt_q == '0) begin
        run_d  = 1'b0;
        done_c = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/tri_setup_unit.sv
// Triangle setup: edges, determinant and reciprocal into a shadow set, committed at frame_sync.
module tri_setup_unit
  import gpu_pkg::*;
#(
  parameter int unsigned INV_W = INV_DET_W,
  parameter int unsigned DET_W = DET_OUT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [VTX_XY_W-1:0]  in_v0_x,
  input  logic [VTX_XY_W-1:0]  in_v0_y,
  input  logic [VTX_Z_W-1:0]   in_v0_z,
  input  logic [VTX_XY_W-1:0]  in_v1_x,
  input  logic [VTX_XY_W-1:0]  in_v1_y,
  input  logic [VTX_Z_W-1:0]   in_v1_z,
  input  logic [VTX_XY_W-1:0]  in_v2_x,
  input  logic [VTX_XY_W-1:0]  in_v2_y,
  input  logic [VTX_Z_W-1:0]   in_v2_z,
  input  logic [COLOR_W-1:0]   in_color,
  input  logic                 in_en,
  input  logic                 frame_sync,
  output logic [VTX_XY_W-1:0]  vertex_0_x,
  output logic [VTX_XY_W-1:0]  vertex_0_y,
  output logic [VTX_Z_W-1:0]   vertex_0_z,
  output logic [EDGE_XY_W-1:0] edge_1_x,
  output logic [EDGE_XY_W-1:0] edge_1_y,
  output logic [EDGE_Z_W-1:0]  edge_1_z,
  output logic [EDGE_XY_W-1:0] edge_2_x,
  output logic [EDGE_XY_W-1:0] edge_2_y,
  output logic [EDGE_Z_W-1:0]  edge_2_z,
  output logic [DET_W-1:0]     determinant,
  output logic [INV_W-1:0]     inv_det,
  output logic [COLOR_W-1:0]   poly_color,
  output logic                 en_polygon,
  output logic                 busy
);

  setup_state_e                  state_q, state_d;
  triangle_cfg_t                 sh_q, sh_d;
  triangle_cfg_t                 act_q, act_d;
  logic signed [DET_FULL_W-1:0]  det_q, det_d;
  logic                          ready_q, ready_d;
  logic                          busy_q, busy_d;
  logic signed [DET_FULL_W-1:0]  e1x_c, e1y_c, e2x_c, e2y_c, det_mul_c;
  logic                          div_start_c;
  logic                          div_done_c;
  logic [INV_W-1:0]              div_quo;

  // Signed cross product of the captured edges.
  always_comb begin
    e1x_c     = DET_FULL_W'($signed(sh_q.e1_x));
    e1y_c     = DET_FULL_W'($signed(sh_q.e1_y));
    e2x_c     = DET_FULL_W'($signed(sh_q.e2_x));
    e2y_c     = DET_FULL_W'($signed(sh_q.e2_y));
    det_mul_c = (e1x_c * e2y_c) - (e1y_c * e2x_c);
  end

  // Next-state, shadow capture and commit logic.
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    act_d       = act_q;
    det_d       = det_q;
    div_start_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sh_d.v0_x        = in_v0_x;
          sh_d.v0_y        = in_v0_y;
          sh_d.v0_z        = in_v0_z;
          sh_d.e1_x        = EDGE_XY_W'(in_v1_x) - EDGE_XY_W'(in_v0_x);
          sh_d.e1_y        = EDGE_XY_W'(in_v1_y) - EDGE_XY_W'(in_v0_y);
          sh_d.e1_z        = EDGE_Z_W'(in_v1_z) - EDGE_Z_W'(in_v0_z);
          sh_d.e2_x        = EDGE_XY_W'(in_v2_x) - EDGE_XY_W'(in_v0_x);
          sh_d.e2_y        = EDGE_XY_W'(in_v2_y) - EDGE_XY_W'(in_v0_y);
          sh_d.e2_z        = EDGE_Z_W'(in_v2_z) - EDGE_Z_W'(in_v0_z);
          sh_d.determinant = '0;
          sh_d.inv_det     = '0;
          sh_d.color       = in_color;
          sh_d.en          = in_en;
          state_d          = ST_MULT;
        end
      end
      ST_MULT: begin
        det_d            = det_mul_c;
        sh_d.determinant = DET_OUT_W'(det_mul_c >>> 2);
        sh_d.en          = sh_q.en & (det_mul_c != '0);
        div_start_c      = (det_mul_c != '0);
        state_d          = (det_mul_c == '0) ? ST_DONE : ST_DIV;
      end
      ST_DIV: begin
        if (div_done_c) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (frame_sync) begin
          act_d         = sh_q;
          act_d.inv_det = (det_q == '0) ? '0 : INV_DET_W'(div_quo);
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State, shadow and active registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      act_q   <= '0;
      det_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      act_q   <= act_d;
      det_q   <= det_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  seq_divider #(
    .N_W (INV_W),
    .D_W (DIVISOR_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start_c),
    .dividend (INV_W'(INV_NUMERATOR)),
    .divisor  (abs_det(det_mul_c)),
    .done_c   (div_done_c),
    .quotient (div_quo)
  );

  assign in_ready    = ready_q;
  assign busy        = busy_q;
  assign vertex_0_x  = act_q.v0_x;
  assign vertex_0_y  = act_q.v0_y;
  assign vertex_0_z  = act_q.v0_z;
  assign edge_1_x    = act_q.e1_x;
  assign edge_1_y    = act_q.e1_y;
  assign edge_1_z    = act_q.e1_z;
  assign edge_2_x    = act_q.e2_x;
  assign edge_2_y    = act_q.e2_y;
  assign edge_2_z    = act_q.e2_z;
  assign determinant = DET_W'(act_q.determinant);
  assign inv_det     = INV_W'(act_q.inv_det);
  assign poly_color  = act_q.color;
  assign en_polygon  = act_q.en;

endmodule

// File: doc/tri_setup_unit.md
Name: tri_setup_unit

Overview:
- Triangle setup stage directly upstream of the pixel core.
- Accepts one triangle per handshake as three compressed vertices, a colour and an enable. Computes the edge vectors, the 2D determinant and the reciprocal magnitude inv_det; inv_det uses a sequential restoring divider.
- Results sit in a shadow register set. They are copied to the active outputs only at frame_sync, so the pixel core never sees a triangle change mid-frame.

Parameters:
- INV_W, 20, inv_det width and divider iteration count.
- DET_W, 12, compressed determinant output width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  triangle presented
- in_ready  out  1  block can accept a triangle
- in_v0_x, in_v0_y, in_v1_x, in_v1_y, in_v2_x, in_v2_y  in  6 each  unsigned vertex x/y
- in_v0_z, in_v1_z, in_v2_z  in  3 each  unsigned vertex depth
- in_color  in  6  polygon colour
- in_en  in  1  polygon enable request
- frame_sync  in  1  one-cycle pulse at frame start; commit point
- vertex_0_x, vertex_0_y  out  6  active v0
- vertex_0_z  out  3  active v0 depth
- edge_1_x, edge_1_y  out  7  signed v1-v0
- edge_1_z  out  4  signed v1-v0 depth
- edge_2_x, edge_2_y  out  7  signed v2-v0
- edge_2_z  out  4  signed v2-v0 depth
- determinant  out  DET_W  signed D>>>2
- inv_det  out  INV_W  floor((2^20-1)/|D|), unsigned
- poly_color  out  6  active colour
- en_polygon  out  1  active enable
- busy  out  1  setup in progress or awaiting commit

Behaviour:
- Reset: all active outputs 0, en_polygon 0, shadow registers 0, FSM to IDLE, in_ready 1, busy 0.
- FSM states: IDLE, MULT, DIV, DONE.
  - IDLE: in_ready=1. When in_valid=1, capture all inputs, compute edges (7-bit/4-bit two's complement, v1-v0 and v2-v0), and go to MULT.
  - MULT (1 cycle): D = e1x*e2y - e1y*e2x, full 14-bit signed, registered. Load divisor |D| (13 bits), dividend 2^20-1 and counter=INV_W-1; go to DIV.
  - DIV: one quotient bit per cycle, MSB first, for exactly INV_W cycles; go to DONE after the bit for counter=0.
  - D==0 (degenerate): skip DIV and go MULT->DONE with shadow inv_det=0 and shadow enable=0.
  - DONE: hold the shadow set. On frame_sync=1, copy shadow to active outputs that cycle (visible next cycle) and go to IDLE.
- Latency: handshake cycle T, MULT at T+1, DIV at T+2..T+21, DONE from T+22. Degenerate triangle: DONE from T+2. Outputs change only at the commit edge.
- in_ready=1 only in IDLE. busy = state!=IDLE. in_valid outside IDLE is ignored; no capture and no error.
- frame_sync outside DONE is ignored; active outputs stay unchanged.
- Arrival order: frame_sync arriving before DONE is not remembered, so commit waits for the next pulse. A triangle accepted in the same cycle as a commit is impossible, because commit leaves DONE and acceptance needs IDLE.
- determinant = D arithmetic-shifted right by 2, truncated to DET_W; it keeps the sign of D.
- en_polygon (shadow) = captured in_en AND (D!=0).
- Reset mid-operation (any state): immediate return to reset values. The active set is cleared too, not preserved.
- The divider never needs an overflow check: |D|>=1 in DIV, so the quotient is at most 2^20-1.

Decomposition:
- Shared package gpu_pkg holds:
  - vertex/edge width constants (VTX_XY_W=6, VTX_Z_W=3, EDGE_XY_W=7, EDGE_Z_W=4, COLOR_W=6);
  - INV_NUMERATOR=20'hFFFFF;
  - FSM state enum;
  - a packed triangle_cfg struct matching the active output bundle, so the pixel core can consume the same struct.
- One sub-module: seq_divider, a restoring unsigned divider with start, done and quotient. Dividend width INV_W, divisor width 13.

Test Plan:
- Basic triangle: v0=(0,0,0), v1=(10,0,0), v2=(0,10,0), en=1, colour 6'h2A, frame_sync at T+30 -> edge_1=(10,0,0), edge_2=(0,10,0), determinant=25, inv_det=10485, en_polygon=1, poly_color=6'h2A; outputs unchanged before the commit cycle.
- Winding swap: v1=(0,10), v2=(10,0) -> determinant=-25 (12'hFE7), inv_det=10485, edge_1_x=0, edge_2_y=0.
- Degenerate: v1=(10,10), v2=(20,20), en=1 -> D=0, inv_det=0, en_polygon=0, DONE at T+2; commit on the next frame_sync.
- Extremes:
  - v1=(63,0), v2=(0,63) -> determinant=992, inv_det=264.
  - v1=(1,0), v2=(0,1) -> determinant=0, inv_det=1048575, en_polygon=in_en.
- Handshake/commit:
  - in_valid held high through DIV: only one capture, in_ready low T+1..commit.
  - frame_sync pulsed at T+5: ignored.
  - Second triangle: accepted only the cycle after commit.
- Reset at T+10 mid-DIV -> next cycle all outputs 0, in_ready=1, busy=0; a fresh triangle then completes normally.
